// File: rtl/cci_mpf_rd_credit_arb.sv
// Round-robin arbiter for the shared FIU c0Tx read channel.
// Tracks outstanding read lines globally and per requester, and supports a drain handshake.
module cci_mpf_rd_credit_arb #(
    parameter int N_REQ            = 4,
    parameter int MAX_ACTIVE_LINES = 512,
    parameter int MAX_PER_REQ      = 128,
    parameter int ID_W             = $clog2(N_REQ),
    parameter int CNT_W            = $clog2(MAX_ACTIVE_LINES) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [2*N_REQ-1:0]   req_len,
    output logic [N_REQ-1:0]     req_grant,
    input  logic                 fiu_alm_full,
    input  logic                 rsp_valid,
    input  logic [ID_W-1:0]      rsp_id,
    input  logic [2:0]           rsp_lines,
    input  logic                 drain_req,
    output logic                 drained,
    output logic [CNT_W-1:0]     active_lines,
    output logic                 not_empty,
    output logic                 err_underflow
);

    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {StRun, StDraining, StDrained} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] per_cnt_q [N_REQ];
    logic [CNT_W-1:0] per_cnt_d [N_REQ];
    logic [CNT_W-1:0] total_q, total_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             drained_q, not_empty_q, err_q;

    logic [SUM_W-1:0] lines [N_REQ];
    logic [N_REQ-1:0] eligible;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [SUM_W-1:0] grant_lines;
    logic             underflow;

    // Sums are one bit wider than the counters so the limit checks cannot wrap.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lines[i]    = SUM_W'(req_len[2*i +: 2]) + SUM_W'(1);
            eligible[i] = req_valid[i] && (state_q == StRun) && !drain_req && !fiu_alm_full &&
                          !reset &&
                          (SUM_W'(per_cnt_q[i]) + lines[i] <= SUM_W'(MAX_PER_REQ)) &&
                          (SUM_W'(total_q) + lines[i] <= SUM_W'(MAX_ACTIVE_LINES));
        end
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_lines = '0;
        req_grant   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
                grant_lines = lines[idx];
            end
        end
        if (grant_found) req_grant[grant_idx] = 1'b1;
    end

    always_comb begin
        if (!grant_found)                      rr_ptr_d = rr_ptr_q;
        else if (int'(grant_idx) == N_REQ - 1) rr_ptr_d = '0;
        else                                   rr_ptr_d = grant_idx + ID_W'(1);
    end

    // Grant is applied before the response so a same-cycle pair nets out correctly.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] removed;
        logic [SUM_W-1:0] tot_sum;
        sum       = '0;
        removed   = '0;
        underflow = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = SUM_W'(per_cnt_q[i]);
            if (grant_found && (int'(grant_idx) == i)) sum = sum + lines[i];
            if (rsp_valid && (int'(rsp_id) == i)) begin
                if (SUM_W'(rsp_lines) > sum) begin
                    removed   = sum;
                    underflow = 1'b1;
                    sum       = '0;
                end else begin
                    removed = SUM_W'(rsp_lines);
                    sum     = sum - removed;
                end
            end
            per_cnt_d[i] = CNT_W'(sum);
        end
        if (rsp_valid && (int'(rsp_id) >= N_REQ)) underflow = 1'b1;
        tot_sum = SUM_W'(total_q) + grant_lines;
        total_d = (removed > tot_sum) ? '0 : CNT_W'(tot_sum - removed);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            total_q     <= '0;
            rr_ptr_q    <= '0;
            drained_q   <= 1'b0;
            not_empty_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < N_REQ; i++) per_cnt_q[i] <= '0;
        end else begin
            total_q     <= total_d;
            rr_ptr_q    <= rr_ptr_d;
            not_empty_q <= grant_found || (total_d != '0);
            if (underflow) err_q <= 1'b1;
            for (int i = 0; i < N_REQ; i++) per_cnt_q[i] <= per_cnt_d[i];
            case (state_q)
                StRun: begin
                    if (drain_req) state_q <= StDraining;
                end
                StDraining: begin
                    if (!drain_req) begin
                        state_q <= StRun;
                    end else if (total_d == '0) begin
                        state_q   <= StDrained;
                        drained_q <= 1'b1;
                    end
                end
                StDrained: begin
                    if (!drain_req) begin
                        state_q   <= StRun;
                        drained_q <= 1'b0;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign drained       = drained_q;
    assign active_lines  = total_q;
    assign not_empty     = not_empty_q;
    assign err_underflow = err_q;

endmodule
